// File: rtl/data_memory_unit.sv
// data_memory_unit: word RAM with byte-lane writes plus an MMIO window (console TX FIFO, STATUS, CYCLE).
// Optional DMEM_ERR_EN: sticky err on misaligned/out-of-range access, out-of-range writes suppressed, reads return DEAD_BEEF.
module data_memory_unit #(
   parameter int unsigned MEM_WORDS = 4096,
   parameter int unsigned TX_DEPTH  = 8,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] rd_addr,
   output logic [31:0] rd_data,
   input  logic [1:0]  wr,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        err
);

   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned PW = $clog2(TX_DEPTH);

   logic [31:0] ram [MEM_WORDS];
   logic [7:0]  fifo_q [TX_DEPTH];

   logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [15:0] ovf_q, ovf_d;
   logic [31:0] cyc_q;

   logic        rd_mmio, wr_mmio, misaligned, ram_wr_req, ram_we;
   logic [3:0]  be;
   logic [31:0] wd;
   logic [PW:0] level;
   logic        empty, full, pop, push_req, push;
   logic [31:0] status;
   logic        unused_rd_lsb;

   assign unused_rd_lsb = ^rd_addr[1:0];

   assign rd_mmio    = (rd_addr[31:16] == MMIO_BASE[31:16]);
   assign wr_mmio    = (wr_addr[31:16] == MMIO_BASE[31:16]);
   assign misaligned = ((wr == 2'b10) && wr_addr[0]) ||
                       ((wr == 2'b11) && (wr_addr[1:0] != 2'b00));
   assign ram_wr_req = (wr != 2'b00) && !wr_mmio;

`ifdef DMEM_ERR_EN
   logic wr_oor, rd_oor, err_q;

   assign wr_oor = ((wr_addr >> (AW + 2)) != 32'd0);
   assign rd_oor = ((rd_addr >> (AW + 2)) != 32'd0);
   assign ram_we = ram_wr_req && !misaligned && !wr_oor && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if ((ram_wr_req && (misaligned || wr_oor)) || (!rd_mmio && rd_oor)) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   // rst_n gates the write so a store in a reset cycle is discarded
   assign ram_we = ram_wr_req && !misaligned && rst_n;
   assign err    = 1'b0;
`endif

   // Store data is replicated across lanes; byte enables pick the target lanes
   always_comb begin
      be = '0;
      wd = wr_data;
      case (wr)
         2'b01: begin
            be = 4'b0001 << wr_addr[1:0];
            wd = {4{wr_data[7:0]}};
         end
         2'b10: begin
            be = wr_addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{wr_data[15:0]}};
         end
         2'b11:   be = 4'b1111;
         default: be = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) ram[wr_addr[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   assign level  = wptr_q - rptr_q;
   assign empty  = (wptr_q == rptr_q);
   assign full   = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
   assign status = {ovf_q, 7'd0, full, 8'(level)};

   always_comb begin
      rd_data = ram[rd_addr[AW+1:2]];
      if (rd_mmio) begin
         case (rd_addr[15:2])
            14'd1:   rd_data = status;
            14'd2:   rd_data = cyc_q;
            default: rd_data = '0;
         endcase
      end
`ifdef DMEM_ERR_EN
      if (!rd_mmio && rd_oor) rd_data = 32'hDEAD_BEEF;
`endif
   end

   // A push into a full FIFO still succeeds when the head leaves on the same edge
   always_comb begin
      pop      = !empty && tx_ready;
      push_req = (wr != 2'b00) && wr_mmio && (wr_addr[15:2] == 14'd0);
      push     = push_req && (!full || pop);
      wptr_d   = wptr_q + {{PW{1'b0}}, push};
      rptr_d   = rptr_q + {{PW{1'b0}}, pop};
      ovf_d    = ovf_q;
      if (push_req && !push && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr_q[PW-1:0]] <= wr_data[7:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= '0;
         cyc_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         cyc_q  <= cyc_q + 32'd1;
      end
   end

   assign tx_valid = !empty;
   assign tx_data  = empty ? 8'h00 : fifo_q[rptr_q[PW-1:0]];

endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: randomized stimulus against a byte-addressed reference model, checked through a scoreboard.
module tb_data_memory_unit;

   localparam int unsigned MEM_WORDS = 4096;
   localparam int unsigned TX_DEPTH  = 8;
   localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
   localparam logic [31:0] A_TX = MMIO_BASE;
   localparam logic [31:0] A_ST = MMIO_BASE + 32'd4;
   localparam logic [31:0] A_CY = MMIO_BASE + 32'd8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] rd_addr = '0;
   logic [31:0] rd_data;
   logic [1:0]  wr = '0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic        err;

   data_memory_unit #(
      .MEM_WORDS(MEM_WORDS),
      .TX_DEPTH (TX_DEPTH),
      .MMIO_BASE(MMIO_BASE)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr      (wr),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_ready(tx_ready),
      .err     (err)
   );

   always #5 clk = ~clk;

   int tbcyc = 0;
   always @(posedge clk) tbcyc <= tbcyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   logic [7:0]  mem_b [int unsigned];
   logic [7:0]  fifo_m [$];
   logic [15:0] ovf_m = '0;
   logic [31:0] cyc_m = '0;
   bit          err_m = 1'b0;

   typedef struct {
      int          cyc;
      bit          chk_rd;
      logic [31:0] rd;
      bit          tv;
      bit          chk_td;
      logic [7:0]  td;
      bit          er;
   } exp_t;
   exp_t sb [$];

   function automatic bit in_mmio(input logic [31:0] a);
      return a[31:16] == MMIO_BASE[31:16];
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, tbcyc);
      end
   endfunction

   // Expected outputs for the current input set, then advance the model by one clock
   task automatic step();
      exp_t        e;
      int unsigned a, n;
      bit          pop, preq, accept, ok;
      if (!rst_n) begin
         fifo_m.delete();
         ovf_m = '0;
         cyc_m = '0;
         err_m = 1'b0;
      end
      e.cyc    = tbcyc;
      e.tv     = (fifo_m.size() != 0);
      e.chk_td = e.tv || !rst_n;
      e.td     = e.tv ? fifo_m[0] : 8'h00;
      e.er     = err_m;
      e.chk_rd = 1'b1;
      e.rd     = '0;
      if (in_mmio(rd_addr)) begin
         if (rd_addr[15:2] == 14'd1)
            e.rd = {ovf_m, 7'd0, (fifo_m.size() == TX_DEPTH), 8'(fifo_m.size())};
         else if (rd_addr[15:2] == 14'd2)
            e.rd = cyc_m;
      end else if (rd_addr >= MEM_WORDS * 4) begin
`ifdef DMEM_ERR_EN
         e.rd = 32'hDEAD_BEEF;
         if (rst_n) err_m = 1'b1;
`else
         e.chk_rd = 1'b0;
`endif
      end
      if (!in_mmio(rd_addr) && e.chk_rd && e.rd != 32'hDEAD_BEEF) begin
         a = ((rd_addr >> 2) % MEM_WORDS) * 4;
         ok = 1'b1;
         for (int unsigned k = 0; k < 4; k++) if (!mem_b.exists(a + k)) ok = 1'b0;
         e.chk_rd = ok;
         if (ok) e.rd = {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
      end
      sb.push_back(e);
      if (!rst_n) return;

      pop  = (fifo_m.size() != 0) && tx_ready;
      preq = 1'b0;
      if (wr != 2'b00) begin
         if (in_mmio(wr_addr)) begin
            preq = (wr_addr[15:2] == 14'd0);
         end else begin
            n = (wr == 2'b01) ? 1 : (wr == 2'b10) ? 2 : 4;
            if ((wr_addr % n) != 0) begin
`ifdef DMEM_ERR_EN
               err_m = 1'b1;
`endif
            end else begin
`ifdef DMEM_ERR_EN
               if (wr_addr >= MEM_WORDS * 4) begin
                  err_m = 1'b1;
                  n = 0;
               end
`endif
               for (int unsigned k = 0; k < n; k++)
                  mem_b[(wr_addr + k) % (MEM_WORDS * 4)] = 8'(wr_data >> (8 * k));
            end
         end
      end
      accept = (fifo_m.size() < TX_DEPTH) || pop;
      if (pop) void'(fifo_m.pop_front());
      if (preq) begin
         if (accept) fifo_m.push_back(wr_data[7:0]);
         else if (ovf_m != 16'hFFFF) ovf_m = ovf_m + 16'd1;
      end
      cyc_m = cyc_m + 32'd1;
   endtask

   task automatic drive(input logic [1:0] w, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [31:0] ra, input bit rdy, input bit rst_v = 1'b1);
      @(posedge clk);
      #1;
      rst_n    = rst_v;
      wr       = w;
      wr_addr  = wa;
      wr_data  = wd;
      rd_addr  = ra;
      tx_ready = rdy;
      step();
   endtask

   // monitor: compares whatever the DUT presents this cycle against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() != 0 && sb[0].cyc <= tbcyc) begin
            e = sb.pop_front();
            if (e.cyc != tbcyc) begin
               chk("stale_expectation", 32'(e.cyc), 32'(tbcyc));
            end else begin
               chk("tx_valid", {31'd0, tx_valid}, {31'd0, e.tv});
               if (e.chk_td) chk("tx_data", {24'd0, tx_data}, {24'd0, e.td});
               if (e.chk_rd) chk("rd_data", rd_data, e.rd);
               chk("err", {31'd0, err}, {31'd0, e.er});
            end
         end
      end
   end

   logic [1:0]  rw;
   logic [31:0] rwa, rwd, rra;
   int unsigned sel;

   initial begin
      repeat (3) drive(2'b00, '0, '0, A_CY, 1'b0, 1'b0);
      drive(2'b00, '0, '0, A_CY, 1'b0);
      drive(2'b00, '0, '0, A_ST, 1'b0);

      // word then byte lane update; low address bits ignored on read
      drive(2'b11, 32'h100, 32'h1122_3344, A_ST, 1'b0);
      drive(2'b01, 32'h102, 32'h0000_00AA, 32'h100, 1'b0);
      drive(2'b00, '0, '0, 32'h100, 1'b0);
      drive(2'b00, '0, '0, 32'h103, 1'b0);

      // read-during-write returns the old word
      drive(2'b11, 32'h40, 32'h0, 32'h0, 1'b0);
      drive(2'b11, 32'h40, 32'h5, 32'h40, 1'b0);
      drive(2'b00, '0, '0, 32'h40, 1'b0);

      // misaligned half and word stores are dropped
      drive(2'b11, 32'h200, 32'h1234_5678, 32'h0, 1'b0);
      drive(2'b10, 32'h201, 32'h0000_BEEF, 32'h200, 1'b0);
      drive(2'b11, 32'h202, 32'hFFFF_FFFF, 32'h200, 1'b0);
      drive(2'b00, '0, '0, 32'h200, 1'b0);

      // overflow: 10 pushes into 8 entries, then drain
      for (int i = 0; i < 10; i++)
         drive(2'($urandom_range(1, 3)), A_TX, 32'h41 + 32'(i), A_ST, 1'b0);
      drive(2'b00, '0, '0, A_ST, 1'b0);
      for (int i = 0; i < 10; i++) drive(2'b00, '0, '0, A_ST, 1'b1);

      // push while full with a simultaneous pop
      for (int i = 0; i < 8; i++) drive(2'b11, A_TX, 32'h60 + 32'(i), A_ST, 1'b0);
      drive(2'b01, A_TX, 32'h55, A_ST, 1'b1);
      drive(2'b00, '0, '0, A_ST, 1'b0);
      for (int i = 0; i < 10; i++) drive(2'b00, '0, '0, A_ST, 1'b1);

      // push and pop request on an empty FIFO
      drive(2'b01, A_TX, 32'h77, A_ST, 1'b1);
      drive(2'b00, '0, '0, A_ST, 1'b0);
      drive(2'b00, '0, '0, A_ST, 1'b1);

      drive(2'b00, '0, '0, A_CY, 1'b0);
      repeat (4) drive(2'b00, '0, '0, 32'h100, 1'b0);
      drive(2'b00, '0, '0, A_CY, 1'b0);

      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 9);
         rw  = 2'($urandom_range(0, 3));
         rwd = $urandom;
         rwa = $urandom_range(0, 255);
         if (sel < 3) rwa = A_TX;
         else if (sel == 3) rwa = A_ST;
         else if (sel == 4) rwa = MMIO_BASE + 32'h10;
         else if (sel == 5) rwa = rwa + MEM_WORDS * 4 * $urandom_range(1, 3);
         sel = $urandom_range(0, 9);
         rra = $urandom_range(0, 255);
         if (sel == 0) rra = A_ST;
         else if (sel == 1) rra = A_CY;
         else if (sel == 2) rra = MMIO_BASE + 32'(4 * $urandom_range(3, 6));
         else if (sel == 3) rra = A_TX;
         drive(rw, rwa, rwd, rra, 1'($urandom_range(0, 1)));
      end

      // reset in mid-drain: FIFO and counter clear at once, the concurrent write is lost
      drive(2'b11, 32'h100, 32'h0BAD_0001, 32'h100, 1'b0);
      for (int i = 0; i < 5; i++) drive(2'b01, A_TX, 32'h30 + 32'(i), A_ST, 1'b0);
      drive(2'b00, '0, '0, A_ST, 1'b1);
      drive(2'b11, 32'h100, 32'hCAFE_F00D, A_CY, 1'b1, 1'b0);
      drive(2'b01, A_TX, 32'h99, 32'h100, 1'b1, 1'b0);
      drive(2'b00, '0, '0, 32'h100, 1'b1);
      drive(2'b00, '0, '0, A_CY, 1'b0);
      drive(2'b00, '0, '0, A_ST, 1'b0);

      repeat (3) @(negedge clk);
      if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
